// File: rtl/activate_diff_pkg.sv
// Shared encodings for the activation-derivative unit.
package activate_diff_pkg;

    // Activation selector codes carried on dense_type.
    localparam int unsigned DT_LINEAR = 0;
    localparam int unsigned DT_RELU   = 1;
    localparam int unsigned DT_LEAKY  = 2;
    localparam int unsigned DT_HTANH  = 3;
    localparam int unsigned DT_QUAD   = 4;

    // Leaky-ReLU negative slope is ONE >> LEAKY_SHIFT.
    localparam int unsigned LEAKY_SHIFT = 3;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_e;

endpackage

// File: rtl/activate_diff_if.sv
// Bundle-in / bundle-out handshake interface of the activation-derivative unit.
interface activate_diff_if #(
    parameter int unsigned size            = 3,
    parameter int unsigned data_size       = 16,
    parameter int unsigned dense_type_size = 4
) ();

    logic                        in_valid;
    logic                        in_ready;
    logic [data_size*size-1:0]   z;
    logic [data_size*size-1:0]   grad;
    logic [dense_type_size-1:0]  dense_type;
    logic [31:0]                 w_layer_index;
    logic [31:0]                 w_row_index;
    logic                        is_update;
    logic                        is_cost_layer;

    logic                        out_valid;
    logic                        out_ready;
    logic [data_size*size-1:0]   dz;
    logic [31:0]                 w_layer_index_out;
    logic [31:0]                 w_row_index_out;
    logic                        is_update_out;
    logic                        is_cost_layer_out;
    logic                        type_err;

    // Unit side.
    modport slave (
        input  in_valid, z, grad, dense_type, w_layer_index, w_row_index,
               is_update, is_cost_layer, out_ready,
        output in_ready, out_valid, dz, w_layer_index_out, w_row_index_out,
               is_update_out, is_cost_layer_out, type_err
    );

    // Producer/consumer side.
    modport master (
        output in_valid, z, grad, dense_type, w_layer_index, w_row_index,
               is_update, is_cost_layer, out_ready,
        input  in_ready, out_valid, dz, w_layer_index_out, w_row_index_out,
               is_update_out, is_cost_layer_out, type_err
    );

endinterface

// File: rtl/activate_diff_elem.sv
// One element of dz = f'(z) * grad in signed Q(frac_bits), with saturation.
module activate_diff_elem
    import activate_diff_pkg::*;
#(
    parameter int unsigned data_size       = 16,
    parameter int unsigned frac_bits       = 8,
    parameter int unsigned dense_type_size = 4
) (
    input  logic signed [data_size-1:0]   z_i,
    input  logic signed [data_size-1:0]   grad_i,
    input  logic [dense_type_size-1:0]    dense_type_i,
    output logic signed [data_size-1:0]   dz_o,
    output logic                          err_o
);

    localparam int unsigned PW = 2 * data_size;

    localparam logic signed [data_size-1:0] One    = data_size'(1 << frac_bits);
    localparam logic signed [data_size-1:0] NegOne = -One;
    localparam logic signed [data_size-1:0] LeakyD = One >>> LEAKY_SHIFT;

    localparam logic signed [PW-1:0] SatMax = PW'({1'b0, {(data_size-1){1'b1}}});
    localparam logic signed [PW-1:0] SatMin = -SatMax - PW'(1);

    localparam logic signed [data_size-1:0] OutMax = {1'b0, {(data_size-1){1'b1}}};
    localparam logic signed [data_size-1:0] OutMin = {1'b1, {(data_size-1){1'b0}}};

    logic signed [data_size-1:0] d;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        shifted;

    // Derivative select; unknown codes force d = 0 and flag an error.
    always_comb begin
        d     = '0;
        err_o = 1'b0;
        case (32'(dense_type_i))
            DT_LINEAR: d = One;
            DT_RELU:   d = (z_i > 0) ? One : '0;
            DT_LEAKY:  d = (z_i > 0) ? One : LeakyD;
            DT_HTANH:  d = ((z_i > NegOne) && (z_i < One)) ? One : '0;
            DT_QUAD:   d = z_i;
            default: begin
                d     = '0;
                err_o = 1'b1;
            end
        endcase
    end

    // Full-width product, floor shift back to Q(frac_bits), then clamp.
    always_comb begin
        prod    = PW'(d) * PW'(grad_i);
        shifted = prod >>> frac_bits;
        if (shifted > SatMax) begin
            dz_o = OutMax;
        end else if (shifted < SatMin) begin
            dz_o = OutMin;
        end else begin
            dz_o = shifted[data_size-1:0];
        end
    end

endmodule

// File: rtl/activate_diff_unit.sv
// Serial activation-derivative unit: one element per cycle through a shared
// multiplier, with the layer/row/update sideband carried alongside the result.
module activate_diff_unit
    import activate_diff_pkg::*;
#(
    parameter int unsigned size            = 3,
    parameter int unsigned data_size       = 16,
    parameter int unsigned frac_bits       = 8,
    parameter int unsigned dense_type_size = 4
) (
    input  logic             clk,
    input  logic             rst,
    activate_diff_if.slave   bus_io
);

    localparam int unsigned    IdxW    = (size > 1) ? $clog2(size) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(size - 1);

    state_e                        state_q, state_d;
    logic [IdxW-1:0]               idx_q, idx_d;
    logic [data_size*size-1:0]     z_q, z_d;
    logic [data_size*size-1:0]     grad_q, grad_d;
    logic [data_size*size-1:0]     dz_q, dz_d;
    logic [dense_type_size-1:0]    type_q, type_d;
    logic [31:0]                   layer_q, layer_d;
    logic [31:0]                   row_q, row_d;
    logic                          upd_q, upd_d;
    logic                          cost_q, cost_d;
    logic                          err_q, err_d;

    logic signed [data_size-1:0]   elem_z;
    logic signed [data_size-1:0]   elem_grad;
    logic signed [data_size-1:0]   elem_dz;
    logic                          elem_err;

    assign elem_z    = z_q[idx_q*data_size +: data_size];
    assign elem_grad = grad_q[idx_q*data_size +: data_size];

    activate_diff_elem #(
        .data_size       (data_size),
        .frac_bits       (frac_bits),
        .dense_type_size (dense_type_size)
    ) u_elem (
        .z_i          (elem_z),
        .grad_i       (elem_grad),
        .dense_type_i (type_q),
        .dz_o         (elem_dz),
        .err_o        (elem_err)
    );

    // Next-state: capture on accept, walk idx through the elements, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        z_d     = z_q;
        grad_d  = grad_q;
        dz_d    = dz_q;
        type_d  = type_q;
        layer_d = layer_q;
        row_d   = row_q;
        upd_d   = upd_q;
        cost_d  = cost_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus_io.in_valid) begin
                    state_d = COMPUTE;
                    idx_d   = '0;
                    z_d     = bus_io.z;
                    grad_d  = bus_io.grad;
                    dz_d    = '0;
                    type_d  = bus_io.dense_type;
                    layer_d = bus_io.w_layer_index;
                    row_d   = bus_io.w_row_index;
                    upd_d   = bus_io.is_update;
                    cost_d  = bus_io.is_cost_layer;
                    err_d   = 1'b0;
                end
            end
            COMPUTE: begin
                dz_d[idx_q*data_size +: data_size] = elem_dz;
                err_d = err_q | elem_err;
                if (idx_q == IdxLast) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus_io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any bundle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            z_q     <= '0;
            grad_q  <= '0;
            dz_q    <= '0;
            type_q  <= '0;
            layer_q <= '0;
            row_q   <= '0;
            upd_q   <= 1'b0;
            cost_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            grad_q  <= grad_d;
            dz_q    <= dz_d;
            type_q  <= type_d;
            layer_q <= layer_d;
            row_q   <= row_d;
            upd_q   <= upd_d;
            cost_q  <= cost_d;
            err_q   <= err_d;
        end
    end

    assign bus_io.in_ready          = (state_q == IDLE);
    assign bus_io.out_valid         = (state_q == DONE);
    assign bus_io.dz                = dz_q;
    assign bus_io.w_layer_index_out = layer_q;
    assign bus_io.w_row_index_out   = row_q;
    assign bus_io.is_update_out     = upd_q;
    assign bus_io.is_cost_layer_out = cost_q;
    assign bus_io.type_err          = err_q;

endmodule

// File: doc/activate_diff_unit.md
Name: activate_diff_unit

Overview:
- Downstream consumer of the activate-diff delay register stage: takes the registered pre-activation vector z plus the upstream gradient and produces dz = f'(z) * grad element-wise, in signed fixed point.
- Processes elements serially through one multiplier, with valid/ready handshakes on both sides.
- Carries the layer/row/update/cost-layer sideband alongside each result so the weight-update stage sees a matched bundle.

Parameters:
- size, 3, number of vector elements.
- data_size, 16, element width, signed two's complement.
- frac_bits, 8, fractional bits of the fixed-point format; ONE = 1 << frac_bits.
- dense_type_size, 4, width of the activation selector.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  unit can accept a bundle.
- z  in  data_size*size  pre-activation vector; element i at [data_size*i +: data_size].
- grad  in  data_size*size  upstream gradient vector, same packing.
- dense_type  in  dense_type_size  activation selector.
- w_layer_index  in  32  sideband.
- w_row_index  in  32  sideband.
- is_update  in  1  sideband.
- is_cost_layer  in  1  sideband.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- dz  out  data_size*size  result vector, same packing.
- w_layer_index_out  out  32  captured sideband.
- w_row_index_out  out  32  captured sideband.
- is_update_out  out  1  captured sideband.
- is_cost_layer_out  out  1  captured sideband.
- type_err  out  1  dense_type was unsupported for this bundle.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - COMPUTE: element index idx runs 0..size-1.
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> COMPUTE on in_valid && in_ready. The same edge captures z, grad, dense_type and all sideband, clears dz and sets idx=0.
  - In COMPUTE, each edge writes element idx of dz and increments idx. After the edge that writes idx=size-1, the state goes to DONE.
  - DONE -> IDLE on out_ready. in_ready returns high in the cycle after the handshake; there is no same-cycle pass-through.
- Latency: out_valid rises exactly size cycles after the accepting edge. Maximum throughput is one bundle per size+2 cycles.
- Derivative d, in Q(frac_bits):
  - 0 linear: d = ONE.
  - 1 relu: d = ONE if z > 0, else 0 (z == 0 gives 0).
  - 2 leaky_relu: d = ONE if z > 0, else ONE >> 3.
  - 3 hard_tanh: d = ONE if -ONE < z < ONE, else 0.
  - 4 quadratic (f = z^2/2): d = z.
  - Any other code: d = 0 and type_err = 1; type_err is held until the next accept.
- Arithmetic:
  - product = d * grad_i, a signed 2*data_size-bit result.
  - The product is arithmetic-shifted right by frac_bits (truncate toward negative infinity).
  - The result saturates to [-2^(data_size-1), 2^(data_size-1)-1].
- While out_valid=1, dz and all *_out outputs are stable and in_valid is ignored.
- Reset:
  - State goes to IDLE, idx=0, out_valid=0, in_ready=1.
  - dz, all sideband outputs and type_err are cleared to 0.
  - Reset in COMPUTE or DONE discards the bundle. Reset wins over any simultaneous handshake.

Decomposition:
- Package activate_diff_pkg:
  - dense type encodings DT_LINEAR=0, DT_RELU=1, DT_LEAKY=2, DT_HTANH=3, DT_QUAD=4.
  - state enum IDLE/COMPUTE/DONE.
  - LEAKY_SHIFT=3.
- Sub-module activate_diff_elem: purely combinational (z_i, grad_i, dense_type) -> (dz_i, err). Contains the derivative select, multiply, shift and saturate. It is instantiated once and muxed by idx.

Test Plan (data_size=16, frac_bits=8, size=3):
- Linear: z={5,-7,9}, grad={256,-512,100}, type 0 -> dz={256,-512,100}; out_valid exactly 3 cycles after accept; sideband echoed (layer 2, row 7).
- ReLU: z={256,0,-5}, grad={300,300,300}, type 1 -> dz={300,0,0}.
- Leaky, then quadratic:
  - z=-1, grad=800, type 2 -> 100.
  - Quadratic z=0x7FFF, grad=0x7FFF -> 0x7FFF (saturated).
  - Quadratic z=-32768, grad=32767 -> -32768.
  - Quadratic z=-256, grad=1 -> -1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> dz/out_valid stable, in_ready=0, a new in_valid is ignored; release -> in_ready=1 on the next cycle and the next bundle is accepted.
- Unsupported type 7: type_err=1 and dz={0,0,0}; the next valid bundle clears type_err.
- Reset mid-operation: rst at idx=1 of COMPUTE -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a fresh bundle then completes correctly.
